// File: rtl/psw_key_scanner.sv
// -----------------------------------------------------------------------------
// psw_key_scanner
//
// Front-end for the AP600 calculator push-switch bank. The four raw active-low
// 5-bit switch buses are inverted, passed through a two-flop synchroniser and
// debounced by a small FSM that accepts exactly one key at a time. Every
// accepted press produces a one-cycle key event for the calculator core and
// starts a short buzzer click.
//
// Parameters
//   DB_LEN   : consecutive stable cycles needed to accept a press or a release
//              (1..255)
//   BEEP_LEN : cycles the beep output stays high per accepted key (0 = off)
//
// Ports
//   clk       in   system clock
//   reset     in   synchronous, active-low reset
//   pswA..D   in   5-bit push-switch buses, active-low (0 = pressed)
//   key_valid out  one-cycle pulse, key event valid this cycle
//   key_idx   out  key index 0..19 (A[b]=b, B[b]=5+b, C[b]=10+b, D[b]=15+b)
//   is_digit  out  key is a numeric key
//   digit     out  digit value when is_digit=1, else 0
//   beep      out  buzzer click, active-high
//   busy      out  high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module psw_key_scanner #(
   parameter int DB_LEN   = 1,
   parameter int BEEP_LEN = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] pswA,
   input  logic [4:0] pswB,
   input  logic [4:0] pswC,
   input  logic [4:0] pswD,
   output logic       key_valid,
   output logic [4:0] key_idx,
   output logic       is_digit,
   output logic [3:0] digit,
   output logic       beep,
   output logic       busy
);

   localparam int          BW     = (BEEP_LEN < 2) ? 1 : $clog2(BEEP_LEN + 1);
   localparam logic [7:0]  DB_THR = 8'(DB_LEN);

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_HELD, S_REL} state_t;

   // Saturating 8-bit increment for the debounce counter.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Keypad layout: {is_digit, digit}. Operator/function keys map to 0.
   function automatic logic [4:0] digit_map(input logic [4:0] idx);
      logic [4:0] r;
      case (idx)
         5'd0:    r = {1'b1, 4'd7};
         5'd1:    r = {1'b1, 4'd8};
         5'd2:    r = {1'b1, 4'd9};
         5'd5:    r = {1'b1, 4'd4};
         5'd6:    r = {1'b1, 4'd5};
         5'd7:    r = {1'b1, 4'd6};
         5'd10:   r = {1'b1, 4'd1};
         5'd11:   r = {1'b1, 4'd2};
         5'd12:   r = {1'b1, 4'd3};
         5'd15:   r = {1'b1, 4'd0};
         default: r = 5'd0;
      endcase
      return r;
   endfunction

   logic [19:0]   press_raw;
   logic [19:0]   sync1_q, sync2_q;
   logic          one_hot, none;
   logic [4:0]    hot_idx;
   logic [7:0]    cnt_inc;

   state_t        state_q, state_d;
   logic [4:0]    cand_q, cand_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          accept;

   logic          key_valid_q;
   logic [4:0]    key_idx_q;
   logic          is_digit_q;
   logic [3:0]    digit_q;
   logic [BW-1:0] beep_cnt_q;
   logic [4:0]    map_d;

   // Bank A occupies the low bits so the bit position equals the key index.
   assign press_raw = ~{pswD, pswC, pswB, pswA};

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= press_raw;
         sync2_q <= sync1_q;
      end
   end

   // Exactly-one-set test: clearing the lowest set bit must leave nothing.
   assign none    = (sync2_q == 20'd0);
   assign one_hot = !none && ((sync2_q & (sync2_q - 20'd1)) == 20'd0);
   assign cnt_inc = sat_inc(cnt_q);

   always_comb begin
      hot_idx = 5'd0;
      for (int i = 0; i < 20; i++) begin
         if (sync2_q[i]) hot_idx = 5'(i);
      end
   end

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (one_hot) begin
               cand_d = hot_idx;
               cnt_d  = 8'd1;
               if (DB_LEN == 1) begin
                  accept  = 1'b1;
                  state_d = S_HELD;
               end else begin
                  state_d = S_CHECK;
               end
            end
         end
         S_CHECK: begin
            // Anything other than the same single key aborts; the aborting
            // sample is not reused as the start of a new candidate.
            if (one_hot && (hot_idx == cand_q)) begin
               cnt_d = cnt_inc;
               if (cnt_inc >= DB_THR) begin
                  accept  = 1'b1;
                  state_d = S_HELD;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_HELD: begin
            if (none) begin
               cnt_d   = 8'd1;
               state_d = (DB_LEN == 1) ? S_IDLE : S_REL;
            end
         end
         S_REL: begin
            if (none) begin
               cnt_d = cnt_inc;
               if (cnt_inc >= DB_THR) state_d = S_IDLE;
            end else begin
               state_d = S_HELD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign map_d = digit_map(cand_d);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cand_q      <= '0;
         cnt_q       <= '0;
         key_valid_q <= 1'b0;
         key_idx_q   <= '0;
         is_digit_q  <= 1'b0;
         digit_q     <= '0;
         beep_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         key_valid_q <= accept;
         if (accept) begin
            key_idx_q  <= cand_d;
            is_digit_q <= map_d[4];
            digit_q    <= map_d[3:0];
         end
         // A new accept reloads the click, restarting an active one.
         if (accept)
            beep_cnt_q <= BW'(BEEP_LEN);
         else if (beep_cnt_q != '0)
            beep_cnt_q <= beep_cnt_q - 1'b1;
      end
   end

   assign key_valid = key_valid_q;
   assign key_idx   = key_idx_q;
   assign is_digit  = is_digit_q;
   assign digit     = digit_q;
   assign beep      = (beep_cnt_q != '0);
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_psw_key_scanner.sv
module tb_psw_key_scanner;

   localparam int BEEP = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [19:0] p1, p4;   // pressed-key vectors (1 = pressed) per DUT
   logic [4:0]  a1, b1, c1, d1, a4, b4, c4, d4;
   assign {d1, c1, b1, a1} = ~p1;
   assign {d4, c4, b4, a4} = ~p4;

   logic       kv1, isd1, bp1, bz1, kv4, isd4, bp4, bz4;
   logic [4:0] idx1, idx4;
   logic [3:0] dig1, dig4;

   psw_key_scanner #(.DB_LEN(1), .BEEP_LEN(BEEP)) u_db1 (
      .clk(clk), .reset(reset), .pswA(a1), .pswB(b1), .pswC(c1), .pswD(d1),
      .key_valid(kv1), .key_idx(idx1), .is_digit(isd1), .digit(dig1),
      .beep(bp1), .busy(bz1));

   psw_key_scanner #(.DB_LEN(4), .BEEP_LEN(BEEP)) u_db4 (
      .clk(clk), .reset(reset), .pswA(a4), .pswB(b4), .pswC(c4), .pswD(d4),
      .key_valid(kv4), .key_idx(idx4), .is_digit(isd4), .digit(dig4),
      .beep(bp4), .busy(bz4));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(string nm, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // A press is taken once DB consecutive samples show the same single key;
   // a sample that breaks a press run is discarded. After a press, nothing is
   // taken until DB consecutive all-released samples have been seen.
   bit [19:0] m_s1[2], m_s2[2];
   int        m_run[2], m_cand[2], m_relrun[2], m_beep[2];
   bit        m_held[2], m_kv[2];
   int        m_idx[2], m_isd[2], m_dig[2];

   function automatic int digit_of(int k);
      int bank, col;
      bank = k / 5;
      col  = k % 5;
      if (k == 15) return 0;
      if (bank < 3 && col < 3) return 7 - 3 * bank + col;
      return -1;
   endfunction

   task automatic model_reset(int u);
      m_s1[u] = '0; m_s2[u] = '0;
      m_run[u] = 0; m_cand[u] = 0; m_relrun[u] = 0; m_beep[u] = 0;
      m_held[u] = 1'b0; m_kv[u] = 1'b0;
      m_idx[u] = 0; m_isd[u] = 0; m_dig[u] = 0;
   endtask

   task automatic model_step(int u, bit [19:0] pin);
      bit [19:0] cur;
      int k, db, d;
      bit one, acc;
      db  = (u == 0) ? 1 : 4;
      cur = m_s2[u];
      m_s2[u] = m_s1[u];
      m_s1[u] = pin;
      m_kv[u] = 1'b0;
      acc = 1'b0;
      if (m_beep[u] > 0) m_beep[u]--;
      one = ($countones(cur) == 1);
      k = 0;
      for (int i = 0; i < 20; i++) if (cur[i]) k = i;
      if (m_held[u]) begin
         if (cur == 0) begin
            m_relrun[u]++;
            if (m_relrun[u] >= db) begin m_held[u] = 1'b0; m_relrun[u] = 0; end
         end else m_relrun[u] = 0;
      end else if (m_run[u] > 0) begin
         if (one && k == m_cand[u]) begin
            m_run[u]++;
            if (m_run[u] >= db) acc = 1'b1;
         end else m_run[u] = 0;
      end else if (one) begin
         m_cand[u] = k;
         m_run[u]  = 1;
         if (db == 1) acc = 1'b1;
      end
      if (acc) begin
         d = digit_of(m_cand[u]);
         m_kv[u]  = 1'b1;
         m_idx[u] = m_cand[u];
         m_isd[u] = (d >= 0) ? 1 : 0;
         m_dig[u] = (d >= 0) ? d : 0;
         m_held[u] = 1'b1; m_run[u] = 0; m_relrun[u] = 0;
         m_beep[u] = BEEP;
      end
   endtask

   always @(posedge clk) begin
      if (!reset) begin
         model_reset(0);
         model_reset(1);
      end else begin
         model_step(0, p1);
         model_step(1, p4);
      end
   end

   // ---------------- output monitor ----------------
   typedef struct {int idx; int isd; int dig;} ev_t;
   ev_t evq0[$], evq1[$];
   int  beep_seen[2];
   bit  mon_en = 1'b0;

   task automatic mon_unit(int u, logic kv, logic [4:0] idx, logic isd,
                           logic [3:0] dig, logic bp, logic bz);
      string t;
      ev_t e;
      t = (u == 0) ? "db1" : "db4";
      chk({t, ".key_valid"}, int'(kv),  int'(m_kv[u]));
      chk({t, ".key_idx"},   int'(idx), m_idx[u]);
      chk({t, ".is_digit"},  int'(isd), m_isd[u]);
      chk({t, ".digit"},     int'(dig), m_dig[u]);
      chk({t, ".beep"},      int'(bp),  (m_beep[u] > 0) ? 1 : 0);
      chk({t, ".busy"},      int'(bz),  (m_held[u] || m_run[u] > 0) ? 1 : 0);
      if (kv) begin
         e.idx = int'(idx); e.isd = int'(isd); e.dig = int'(dig);
         if (u == 0) evq0.push_back(e); else evq1.push_back(e);
      end
      if (bp) beep_seen[u]++;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon_unit(0, kv1, idx1, isd1, dig1, bp1, bz1);
         mon_unit(1, kv4, idx4, isd4, dig4, bp4, bz4);
      end
   end

   task automatic tick(int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   function automatic bit [19:0] rand_pat();
      int r;
      bit [19:0] v;
      r = $urandom_range(0, 9);
      v = '0;
      if (r >= 4) v[$urandom_range(0, 19)] = 1'b1;
      if (r == 9) v[$urandom_range(0, 19)] = 1'b1;
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   typedef struct {int key; int e_idx; int e_isd; int e_dig;} vec_t;
   vec_t tbl[6];

   initial begin
      int lat, fall, h1, h4;
      // log, 1, 0, +, 5, =
      tbl[0] = '{16, 16, 0, 0};
      tbl[1] = '{10, 10, 1, 1};
      tbl[2] = '{15, 15, 1, 0};
      tbl[3] = '{18, 18, 0, 0};
      tbl[4] = '{ 6,  6, 1, 5};
      tbl[5] = '{19, 19, 0, 0};

      reset = 1'b0; p1 = '0; p4 = '0;
      tick(3);
      mon_en = 1'b1;
      chk("rst.key_valid", int'(kv1) + int'(kv4), 0);
      chk("rst.key_idx",   int'(idx1) + int'(idx4), 0);
      chk("rst.is_digit",  int'(isd1) + int'(isd4), 0);
      chk("rst.digit",     int'(dig1) + int'(dig4), 0);
      chk("rst.beep",      int'(bp1) + int'(bp4), 0);
      chk("rst.busy",      int'(bz1) + int'(bz4), 0);
      reset = 1'b1;
      tick(2);

      // single 1-cycle press of C0 on DB_LEN=1
      evq0.delete(); beep_seen[0] = 0;
      p1[10] = 1'b1; tick(1); p1 = '0; tick(12);
      chk("c0.events", evq0.size(), 1);
      if (evq0.size() > 0) begin
         chk("c0.idx", evq0[0].idx, 10);
         chk("c0.isd", evq0[0].isd, 1);
         chk("c0.dig", evq0[0].dig, 1);
      end
      chk("c0.beep_cycles", beep_seen[0], 8);

      // key sequence table
      evq0.delete();
      for (int i = 0; i < 6; i++) begin
         p1 = '0; p1[tbl[i].key] = 1'b1; tick(1);
         p1 = '0; tick(1);
      end
      tick(6);
      chk("seq.events", evq0.size(), 6);
      for (int i = 0; i < 6; i++) begin
         if (i < evq0.size()) begin
            chk($sformatf("seq[%0d].idx", i), evq0[i].idx, tbl[i].e_idx);
            chk($sformatf("seq[%0d].isd", i), evq0[i].isd, tbl[i].e_isd);
            chk($sformatf("seq[%0d].dig", i), evq0[i].dig, tbl[i].e_dig);
         end
      end

      // two keys together, then one released
      evq0.delete();
      p1 = '0; p1[2] = 1'b1; p1[6] = 1'b1; tick(10);
      chk("multi.events_both", evq0.size(), 0);
      p1[6] = 1'b0; tick(6);
      chk("multi.events", evq0.size(), 1);
      if (evq0.size() > 0) begin
         chk("multi.idx", evq0[0].idx, 2);
         chk("multi.dig", evq0[0].dig, 9);
      end
      p1 = '0; tick(4);

      // DB_LEN=4: glitch rejected, real press latency
      evq1.delete();
      p4[13] = 1'b1; tick(3); p4 = '0; tick(12);
      chk("glitch.events", evq1.size(), 0);
      lat = 0;
      p4[13] = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         tick(1);
         if (kv4 && lat == 0) lat = n;
      end
      p4 = '0; tick(10);
      chk("c3.latency", lat, 6);
      chk("c3.events", evq1.size(), 1);
      if (evq1.size() > 0) chk("c3.idx", evq1[0].idx, 13);

      // long hold of D4 with B0 chatter
      evq1.delete();
      for (int n = 1; n <= 50; n++) begin
         p4 = '0; p4[19] = 1'b1;
         if (n >= 10 && (n % 4) < 2) p4[5] = 1'b1;
         tick(1);
         if (n >= 3) chk("hold.busy", int'(bz4), 1);
      end
      p4 = '0; fall = 0;
      for (int n = 1; n <= 10; n++) begin
         tick(1);
         if (!bz4 && fall == 0) fall = n;
      end
      chk("hold.release_latency", fall, 6);
      chk("hold.events", evq1.size(), 1);
      if (evq1.size() > 0) begin
         chk("hold.idx", evq1[0].idx, 19);
         chk("hold.isd", evq1[0].isd, 0);
      end

      // reset in CHECK (DB_LEN=4) and during a beep (DB_LEN=1)
      evq0.delete(); evq1.delete();
      p4 = '0; p4[7] = 1'b1; p1 = '0; p1[0] = 1'b1;
      tick(4);
      chk("midrst.busy_before", int'(bz4), 1);
      chk("midrst.beep_before", int'(bp1), 1);
      reset = 1'b0; tick(1);
      chk("midrst.outs4", int'(kv4) + int'(idx4) + int'(isd4) + int'(dig4)
                          + int'(bp4) + int'(bz4), 0);
      chk("midrst.outs1", int'(kv1) + int'(idx1) + int'(isd1) + int'(dig1)
                          + int'(bp1) + int'(bz1), 0);
      reset = 1'b1; lat = 0;
      for (int n = 1; n <= 12; n++) begin
         tick(1);
         if (kv4 && lat == 0) lat = n;
      end
      p4 = '0; p1 = '0; tick(8);
      chk("midrst.latency", lat, 6);
      chk("midrst.events", evq1.size(), 1);
      if (evq1.size() > 0) chk("midrst.idx", evq1[0].idx, 7);
      chk("midrst.events_db1", evq0.size(), 2);

      // randomized traffic against the model
      evq0.delete(); evq1.delete();
      h1 = 0; h4 = 0;
      for (int n = 0; n < 3000; n++) begin
         if (h1 == 0) begin p1 = rand_pat(); h1 = $urandom_range(1, 6); end
         if (h4 == 0) begin p4 = rand_pat(); h4 = $urandom_range(1, 9); end
         h1--; h4--;
         reset = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
         tick(1);
      end
      reset = 1'b1; p1 = '0; p4 = '0; tick(12);
      chk("rand.db1_active", (evq0.size() > 20) ? 1 : 0, 1);
      chk("rand.db4_active", (evq1.size() > 5) ? 1 : 0, 1);

      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
